// File: rtl/seg_scan_mux.sv
// seg_scan_mux
//   Time-multiplexed scanner for a common-anode seven-segment display of up
//   to eight digits. Each digit gets a slot of SCAN_CYCLES clocks. The first
//   clock of every slot is a deghost gap where all anodes are off. Display
//   content is double buffered. A load lands in the pending buffer, and the
//   pending buffer is copied into the active buffer only on the last clock of
//   the frame, so a frame never mixes old and new content. A free-running
//   blink counter supplies the phase used to flash LE-masked digits.
//
// Ports
//   clk        in   1   system clock, rising edge
//   rstn       in   1   synchronous active-low reset
//   load       in   1   one-cycle strobe; captures data_in/point_in/le_in
//   data_in    in  32   digit i nibble at [4i+3:4i]
//   point_in   in   8   decimal point per digit
//   le_in      in   8   blank mask per digit
//   flash_en   in   1   1: masked digits blink, 0: masked digits stay blank
//   an         out  8   active-low anode select, at most one bit low
//   hex        out  4   nibble of the current digit
//   point      out  1   point bit of the current digit
//   le         out  1   LE bit of the current digit
//   flash      out  1   flash_en ? blink_phase : 1
//   pending    out  1   loaded content is waiting for a frame boundary
//   frame_tick out  1   pulse on the final clock of the last digit slot
//
// Load strobe semantics: load has no ready. A load is accepted in every cycle
// in which it is high. A later load before the swap overwrites the pending
// content, so the last load wins.

module seg_scan_mux #(
    parameter int DIGITS       = 8,
    parameter int SCAN_CYCLES  = 100000,
    parameter int BLINK_CYCLES = 25000000
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        load,
    input  logic [31:0] data_in,
    input  logic [7:0]  point_in,
    input  logic [7:0]  le_in,
    input  logic        flash_en,
    output logic [7:0]  an,
    output logic [3:0]  hex,
    output logic        point,
    output logic        le,
    output logic        flash,
    output logic        pending,
    output logic        frame_tick
);

    localparam int DW  = 4 * DIGITS;
    localparam int SCW = $clog2(SCAN_CYCLES);
    localparam int BW  = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;
    localparam int IW  = $clog2(DIGITS);

    localparam logic [SCW-1:0] SC_LAST  = SCW'(SCAN_CYCLES - 1);
    localparam logic [BW-1:0]  BC_LAST  = BW'(BLINK_CYCLES - 1);
    localparam logic [IW-1:0]  IDX_LAST = IW'(DIGITS - 1);

    // Scan position
    logic [SCW-1:0]    sc;
    logic [IW-1:0]     idx;
    logic              slot_end;

    // Blink generator
    logic [BW-1:0]     bc;
    logic              blink_phase;

    // Double-buffered display content
    logic [DW-1:0]     act_data;
    logic [DIGITS-1:0] act_point;
    logic [DIGITS-1:0] act_le;
    logic [DW-1:0]     pend_data;
    logic [DIGITS-1:0] pend_point;
    logic [DIGITS-1:0] pend_le;
    logic              pend_flag;

    assign slot_end   = (sc == SC_LAST);
    assign frame_tick = slot_end && (idx == IDX_LAST);
    assign pending    = pend_flag;
    assign flash      = flash_en ? blink_phase : 1'b1;

    // Scan counter and digit index
    always_ff @(posedge clk) begin
        if (!rstn) begin
            sc  <= '0;
            idx <= '0;
        end else begin
            if (slot_end) begin
                sc  <= '0;
                idx <= (idx == IDX_LAST) ? '0 : idx + IW'(1);
            end else begin
                sc  <= sc + SCW'(1);
            end
        end
    end

    // Blink counter: free running, unaffected by scanning or loads
    always_ff @(posedge clk) begin
        if (!rstn) begin
            bc          <= '0;
            blink_phase <= 1'b0;
        end else if (bc == BC_LAST) begin
            bc          <= '0;
            blink_phase <= ~blink_phase;
        end else begin
            bc          <= bc + BW'(1);
        end
    end

    // Load and frame-boundary swap. A load that coincides with the frame tick
    // bypasses the pending buffer and goes straight to the active buffer.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            act_data   <= '0;
            act_point  <= '0;
            act_le     <= '0;
            pend_data  <= '0;
            pend_point <= '0;
            pend_le    <= '0;
            pend_flag  <= 1'b0;
        end else if (frame_tick) begin
            if (load) begin
                act_data  <= data_in[DW-1:0];
                act_point <= point_in[DIGITS-1:0];
                act_le    <= le_in[DIGITS-1:0];
            end else if (pend_flag) begin
                act_data  <= pend_data;
                act_point <= pend_point;
                act_le    <= pend_le;
            end
            pend_flag <= 1'b0;
        end else if (load) begin
            pend_data  <= data_in[DW-1:0];
            pend_point <= point_in[DIGITS-1:0];
            pend_le    <= le_in[DIGITS-1:0];
            pend_flag  <= 1'b1;
        end
    end

    // Digit select. hex/point/le track idx in every cycle; only the anode is
    // held off during the deghost gap at sc == 0.
    always_comb begin
        an    = 8'hFF;
        hex   = 4'h0;
        point = 1'b0;
        le    = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (idx == IW'(i)) begin
                hex   = act_data[4*i +: 4];
                point = act_point[i];
                le    = act_le[i];
                if (sc != '0) begin
                    an[i] = 1'b0;
                end
            end
        end
    end

endmodule
